date_counter: RTL

DATE_COUNTER -- requirements
Module: date_counter

---
 rtl/calendar_pkg.sv | 30 +++
 rtl/days_in_month.sv | 32 +++
 rtl/date_counter.sv | 113 +++++++++++
 3 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar field widths, reset date and month encodings for the date counter.
// Build option: define DATE_COUNTER_LEAP_YEAR_EN to give February 29 days in leap years.
package calendar_pkg;

    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 7;

    localparam logic [YEAR_W-1:0] MAX_YEAR = 7'd99;

    typedef enum logic [MON_W-1:0] {
        M_JAN = 4'd1,
        M_FEB = 4'd2,
        M_MAR = 4'd3,
        M_APR = 4'd4,
        M_MAY = 4'd5,
        M_JUN = 4'd6,
        M_JUL = 4'd7,
        M_AUG = 4'd8,
        M_SEP = 4'd9,
        M_OCT = 4'd10,
        M_NOV = 4'd11,
        M_DEC = 4'd12
    } month_e;

    localparam logic [DAY_W-1:0]  RST_DAY   = 5'd1;
    localparam logic [MON_W-1:0]  RST_MONTH = 4'd1;
    localparam logic [YEAR_W-1:0] RST_YEAR  = 7'd0;

endpackage

// File: rtl/days_in_month.sv
// Combinational month-length lookup; returns 0 for month codes outside 1..12.
// Build option: DATE_COUNTER_LEAP_YEAR_EN selects 29-day February when year[1:0]==0.
module days_in_month
    import calendar_pkg::*;
(
    input  logic [MON_W-1:0]  i_month,
    input  logic [YEAR_W-1:0] i_year,
    output logic [DAY_W-1:0]  o_len
);

    logic w_leap;
    logic w_unused_year;

`ifdef DATE_COUNTER_LEAP_YEAR_EN
    // Within 2000..2099 every year divisible by 4 is a leap year.
    assign w_leap = (i_year[1:0] == 2'b00);
`else
    assign w_leap = 1'b0;
`endif
    assign w_unused_year = ^i_year;

    always_comb begin
        o_len = 5'd0;
        case (i_month)
            M_JAN, M_MAR, M_MAY, M_JUL, M_AUG, M_OCT, M_DEC: o_len = 5'd31;
            M_APR, M_JUN, M_SEP, M_NOV:                      o_len = 5'd30;
            M_FEB:                                           o_len = w_leap ? 5'd29 : 5'd28;
            default:                                         o_len = 5'd0;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// Day/month/year counter advanced by rising edges of an upstream day-carry, with validated date load.
// Build option: DATE_COUNTER_LEAP_YEAR_EN enables leap-year February.
module date_counter
    import calendar_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc_day,
    input  logic              i_load,
    input  logic [DAY_W-1:0]  i_load_day,
    input  logic [MON_W-1:0]  i_load_month,
    input  logic [YEAR_W-1:0] i_load_year,
    output logic [DAY_W-1:0]  o_day,
    output logic [MON_W-1:0]  o_month,
    output logic [YEAR_W-1:0] o_year,
    output logic              o_new_year,
    output logic              o_load_err
);

    logic [DAY_W-1:0]  r_day;
    logic [MON_W-1:0]  r_month;
    logic [YEAR_W-1:0] r_year;
    logic              r_new_year;
    logic              r_load_err;
    logic              r_inc_s;
    logic              r_inc_d;

    logic [DAY_W-1:0]  w_cur_len;
    logic [DAY_W-1:0]  w_ld_len;
    logic              w_adv_req;
    logic              w_ld_valid;
    logic [DAY_W-1:0]  w_day_next;
    logic [MON_W-1:0]  w_month_next;
    logic [YEAR_W-1:0] w_year_next;
    logic              w_new_year_next;
    logic              w_load_err_next;

    days_in_month u_cur_len (
        .i_month (r_month),
        .i_year  (r_year),
        .o_len   (w_cur_len)
    );

    days_in_month u_ld_len (
        .i_month (i_load_month),
        .i_year  (i_load_year),
        .o_len   (w_ld_len)
    );

    assign w_adv_req  = r_inc_s & ~r_inc_d;
    // An out-of-range month yields a zero length, so the day bound also rejects it.
    assign w_ld_valid = (i_load_month >= 4'd1) && (i_load_month <= 4'd12) &&
                        (i_load_year <= MAX_YEAR) &&
                        (i_load_day != 5'd0) && (i_load_day <= w_ld_len);

    always_comb begin
        w_day_next      = r_day;
        w_month_next    = r_month;
        w_year_next     = r_year;
        w_new_year_next = 1'b0;
        w_load_err_next = 1'b0;
        if (i_load) begin
            if (w_ld_valid) begin
                w_day_next   = i_load_day;
                w_month_next = i_load_month;
                w_year_next  = i_load_year;
            end else begin
                w_load_err_next = 1'b1;
            end
        end else if (w_adv_req) begin
            if (r_day < w_cur_len) begin
                w_day_next = r_day + 5'd1;
            end else begin
                w_day_next = 5'd1;
                if (r_month == M_DEC) begin
                    w_month_next    = 4'd1;
                    w_year_next     = (r_year >= MAX_YEAR) ? 7'd0 : r_year + 7'd1;
                    w_new_year_next = 1'b1;
                end else begin
                    w_month_next = r_month + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_day      <= RST_DAY;
            r_month    <= RST_MONTH;
            r_year     <= RST_YEAR;
            r_new_year <= 1'b0;
            r_load_err <= 1'b0;
            r_inc_s    <= 1'b0;
            r_inc_d    <= 1'b0;
        end else begin
            r_day      <= w_day_next;
            r_month    <= w_month_next;
            r_year     <= w_year_next;
            r_new_year <= w_new_year_next;
            r_load_err <= w_load_err_next;
            r_inc_s    <= i_inc_day;
            // A load also swallows a rise sampled on the same edge, so it never advances later.
            r_inc_d    <= i_load ? 1'b1 : r_inc_s;
        end
    end

    assign o_day      = r_day;
    assign o_month    = r_month;
    assign o_year     = r_year;
    assign o_new_year = r_new_year;
    assign o_load_err = r_load_err;

endmodule
